// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, converter state type and the double-dabble nibble adjust.
package seg_pkg;
    localparam int SEG_DIGITS = 5;
    localparam logic [3:0] SEG_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

    // Add 3 to every BCD nibble >= 5 so the following left shift carries correctly.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < SEG_DIGITS; i++)
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 16-bit binary to 5 BCD digits in 16 shift cycles.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        ready,
    output logic        done,
    output logic [19:0] bcd
);
    conv_state_t state;
    logic [35:0] sr;
    logic [3:0]  cnt;

    assign bcd = sr[35:16];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sr    <= {20'b0, bin};
                    cnt   <= '0;
                    ready <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sr  <= {dabble_adjust(sr[35:16]), sr[15:0]} << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: value handshake, BCD display register and 5-digit anode scan.
// Define SEG_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iValid,
    output logic        oReady,
    input  logic [15:0] iData,
    output logic [3:0]  oDigit,
    output logic [7:0]  oAn
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic          done;
    logic [19:0]   bcd;
    logic [19:0]   disp;
    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [3:0]    digit_next;
    logic          blank;

    bin2bcd_seq u_conv (
        .clk   (iClk),
        .rst_n (iRst_n),
        .start (iValid && oReady),
        .bin   (iData),
        .ready (oReady),
        .done  (done),
        .bcd   (bcd)
    );

    always_comb begin
`ifdef SEG_LZ_BLANK_EN
        blank = (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 20'd0);
`else
        blank = 1'b0;
`endif
        digit_next = blank ? SEG_BLANK : disp[{idx, 2'b00} +: 4];
    end

    // Outputs follow idx by one edge so a display update lands on the next digit refresh.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            disp   <= '0;
            pre    <= '0;
            idx    <= '0;
            oAn    <= 8'hFE;
            oDigit <= 4'h0;
        end else begin
            if (done)
                disp <= bcd;
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            if (pre == PRE_LAST)
                idx <= (idx == 3'(SEG_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            oAn    <= ~(8'b1 << idx);
            oDigit <= digit_next;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed vector table plus multi-cycle handshake/reset sequences, SCAN_DIV=4.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic        ready;
    logic [3:0]  digit;
    logic [7:0]  an;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] value;
        logic [19:0] bcd;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iValid (valid),
        .oReady (ready),
        .iData  (data),
        .oDigit (digit),
        .oAn    (an)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] shown(input logic [19:0] b, input int i);
`ifdef SEG_LZ_BLANK_EN
        if (i > 0 && (b >> (4 * i)) == 20'd0) return 4'hF;
`endif
        return b[4*i +: 4];
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s: oReady still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic check_digits(input string name, input logic [19:0] b);
        logic [7:0] tgt;
        tick();
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            tgt = ~(8'b1 << i);
            while (an !== tgt && n < 40) begin
                tick();
                n++;
            end
            if (an !== tgt) begin
                checks++;
                errors++;
                $display("FAIL %s scan: oAn %0h never reached %0h", name, an, tgt);
            end else
                check($sformatf("%s d%0d", name, i), digit, shown(b, i));
        end
    endtask

    task automatic send(input logic [15:0] v, output int low);
        valid = 1'b1;
        data  = v;
        wait_ready("send idle");
        tick();
        valid = 1'b0;
        low = 0;
        while (!ready && low < 100) begin
            tick();
            low++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int low;
        int c;
        logic [7:0] scan_exp[6];
        vecs[0] = '{16'd12345, 20'h12345};
        vecs[1] = '{16'd907,   20'h00907};
        vecs[2] = '{16'd65535, 20'h65535};
        vecs[3] = '{16'd0,     20'h00000};
        vecs[4] = '{16'd9,     20'h00009};
        vecs[5] = '{16'd10000, 20'h10000};
        vecs[6] = '{16'd100,   20'h00100};
        vecs[7] = '{16'd40960, 20'h40960};
        scan_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFE};

        tick(3);
        check("reset ready", ready, 1);
        check("reset an", an, 8'hFE);
        check("reset digit", digit, 4'h0);
        rst_n = 1'b1;
        tick(2);
        for (int s = 0; s < 6; s++) begin
            check($sformatf("scan step %0d", s), an, scan_exp[s]);
            tick(4);
        end

        for (int k = 0; k < 8; k++) begin
            send(vecs[k].value, low);
            check($sformatf("busy len %0d", vecs[k].value), low, 17);
            check_digits($sformatf("val %0d", vecs[k].value), vecs[k].bcd);
        end

        // back-to-back with iValid held high
        valid = 1'b1;
        data  = 16'd65535;
        wait_ready("b2b first");
        tick();
        data = 16'd0;
        c = 0;
        while (!ready && c < 100) begin
            tick();
            c++;
        end
        check("b2b gap", c + 1, 18);
        tick();
        valid = 1'b0;
        wait_ready("b2b second");
        check_digits("b2b zero", 20'h00000);

        // iValid pulse during SHIFT is ignored
        valid = 1'b1;
        data  = 16'd1111;
        wait_ready("ignore idle");
        tick();
        valid = 1'b0;
        tick(5);
        valid = 1'b1;
        data  = 16'd4321;
        tick();
        valid = 1'b0;
        low = 0;
        while (!ready && low < 100) begin
            tick();
            low++;
        end
        check("ignore busy rest", low, 11);
        tick(3);
        check("ignore no restart", ready, 1);
        check_digits("ignore", 20'h01111);

        // reset at SHIFT cycle 8 abandons the conversion
        valid = 1'b1;
        data  = 16'd9999;
        wait_ready("rst idle");
        tick();
        valid = 1'b0;
        tick(8);
        check("mid busy", ready, 0);
        rst_n = 1'b0;
        tick();
        check("mid rst ready", ready, 1);
        check("mid rst an", an, 8'hFE);
        check("mid rst digit", digit, 4'h0);
        rst_n = 1'b1;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ready) c++;
        end
        check("mid no busy", c, 0);
        check_digits("mid rst", 20'h00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
